if_id_stage: RTL

- Fetch stage plus IF/ID pipeline register for the 5-stage RV64 pipelined processor.
- Owns the PC, drives the instruction-memory address, and latches the fetched instruction and its PC for decode.
- Contains the load-use hazard detection that stalls fetch/decode and requests a bubble into ID/EX.
- Applies the branch redirect and flush resolved in EX/MEM (Branch_exmem_out & Zero_exmem_out).

---
 rtl/rv_pipe_pkg.sv | 23 ++
 rtl/hazard_detection_unit.sv | 35 +++
 rtl/if_id_stage.sv | 82 ++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared constants for the RV64 5-stage pipeline: opcodes, the canonical NOP
// and the instruction field positions used by hazard decode.
package rv_pipe_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam int REG_W    = 5;
    localparam int OPCODE_W = 7;
    localparam int RD_LSB   = 7;
    localparam int RS1_LSB  = 15;
    localparam int RS2_LSB  = 20;

endpackage

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detection: flags when the instruction in IF/ID reads the
// register that a load currently in ID/EX is about to write.
module hazard_detection_unit
    import rv_pipe_pkg::*;
(
    input  logic [31:0] ifid_instr,
    input  logic        ifid_valid,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        hazard
);

    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic                unused_fields;

    assign opcode = ifid_instr[OPCODE_W-1:0];
    assign rs1    = ifid_instr[RS1_LSB +: REG_W];
    assign rs2    = ifid_instr[RS2_LSB +: REG_W];

    assign unused_fields = ^{ifid_instr[31:25], ifid_instr[14:7]};

    // U-type and JAL carry immediate bits where rs1 would sit, so they never read it
    assign uses_rs1 = ifid_valid &&
                      (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    assign uses_rs2 = ifid_valid &&
                      ((opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH));

    assign hazard = idex_memread && (idex_rd != '0) &&
                    ((uses_rs1 && (rs1 == idex_rd)) || (uses_rs2 && (rs2 == idex_rd)));

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, applies EX/MEM
// redirects, and stalls one cycle on load-use hazards.
module if_id_stage #(
    parameter int                PC_WIDTH  = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h00000013,
    parameter int                CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [PC_WIDTH-1:0]  inst_addr,
    input  logic [31:0]          inst_data,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic                 idex_memread,
    input  logic [4:0]           idex_rd,
    output logic [PC_WIDTH-1:0]  ifid_pc,
    output logic [31:0]          ifid_instr,
    output logic                 ifid_valid,
    output logic                 id_bubble,
    output logic                 pipe_flush,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    logic [PC_WIDTH-1:0] pc;
    logic                hazard;
    logic                unused_uses_rs1;
    logic                unused_uses_rs2;
    logic                unused_target_lsbs;

    hazard_detection_unit u_hdu (
        .ifid_instr   (ifid_instr),
        .ifid_valid   (ifid_valid),
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .uses_rs1     (unused_uses_rs1),
        .uses_rs2     (unused_uses_rs2),
        .hazard       (hazard)
    );

    assign inst_addr  = pc;
    assign pipe_flush = branch_taken;
    // A redirect squashes the decode instruction, so there is nothing left to stall
    assign id_bubble  = hazard && !branch_taken;

    assign unused_target_lsbs = ^branch_target[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (branch_taken) begin
            pc         <= {branch_target[PC_WIDTH-1:2], 2'b00};
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (!hazard) begin
            pc         <= pc + PC_WIDTH'(4);
            ifid_pc    <= pc;
            ifid_instr <= inst_data;
            ifid_valid <= 1'b1;
        end
    end

    // Performance counters stick at all-ones instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (branch_taken) begin
            if (flush_count != '1)
                flush_count <= flush_count + CNT_WIDTH'(1);
        end else if (hazard) begin
            if (stall_count != '1)
                stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

endmodule
